// File: rtl/oka_pkg.sv
// Shared constants, FSM encoding and recombination helper for the folded
// 30-bit odd/even Karatsuba multiplier.
package oka_pkg;

  localparam int unsigned N  = 30;
  localparam int unsigned H  = 15;
  localparam int unsigned PW = 29;
  localparam int unsigned YW = 59;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_E = 3'd1,
    MUL_O = 3'd2,
    MUL_M = 3'd3,
    DONE  = 3'd4
  } oka_state_t;

  // Even output bits take E[i]^O[i-1]; odd bits take M[i]^E[i]^O[i].
  function automatic logic [YW-1:0] recombine(input logic [PW-1:0] e,
                                              input logic [PW-1:0] o,
                                              input logic [PW-1:0] m);
    logic [YW-1:0] r;
    logic [PW:0]   e_x;
    logic [PW:0]   o_x;
    r   = '0;
    e_x = {1'b0, e};
    o_x = {o, 1'b0};
    for (int unsigned i = 0; i <= PW; i++) begin
      r[2*i] = e_x[i] ^ o_x[i];
    end
    for (int unsigned i = 0; i < PW; i++) begin
      r[2*i+1] = m[i] ^ e[i] ^ o[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/CA_15bit.sv
// Combinational 15x15 carry-less (GF(2)[x]) multiplier, 29-bit product.
module CA_15bit
  import oka_pkg::*;
(
  input  logic [H-1:0]  a,
  input  logic [H-1:0]  b,
  output logic [PW-1:0] y
);

  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < H; i++) begin
      if (b[i]) begin
        y = y ^ ({{(PW-H){1'b0}}, a} << i);
      end
    end
  end

endmodule

// File: rtl/oka_30bit_seq.sv
// Folded OKA multiplier: one CA_15bit is time-shared over the E, O and M
// half products, then the results are recombined into the 59-bit product.
module oka_30bit_seq
  import oka_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] y,
  output logic          busy,
  output logic [15:0]   op_cnt
);

  oka_state_t    state, state_nxt;
  logic [N-1:0]  a_r, b_r;
  logic [PW-1:0] e_r, o_r;
  logic [YW-1:0] y_r;
  logic [15:0]   op_cnt_r;

  logic [H-1:0]  a_e, a_o, b_e, b_o;
  logic [H-1:0]  ca_a, ca_b;
  logic [PW-1:0] ca_y;

  always_comb begin
    a_e = '0;
    a_o = '0;
    b_e = '0;
    b_o = '0;
    for (int unsigned i = 0; i < H; i++) begin
      a_e[i] = a_r[2*i];
      a_o[i] = a_r[2*i+1];
      b_e[i] = b_r[2*i];
      b_o[i] = b_r[2*i+1];
    end
  end

  always_comb begin
    ca_a = a_e ^ a_o;
    ca_b = b_e ^ b_o;
    case (state)
      MUL_E: begin
        ca_a = a_e;
        ca_b = b_e;
      end
      MUL_O: begin
        ca_a = a_o;
        ca_b = b_o;
      end
      default: ;
    endcase
  end

  CA_15bit u_ca (
    .a (ca_a),
    .b (ca_b),
    .y (ca_y)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MUL_E;
      end
      MUL_E: state_nxt = MUL_O;
      MUL_O: state_nxt = MUL_M;
      MUL_M: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      e_r      <= '0;
      o_r      <= '0;
      y_r      <= '0;
      op_cnt_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:  if (in_valid) begin
          a_r <= a;
          b_r <= b;
        end
        MUL_E: e_r <= ca_y;
        MUL_O: o_r <= ca_y;
        MUL_M: y_r <= recombine(e_r, o_r, ca_y);
        DONE:  if (out_ready) op_cnt_r <= op_cnt_r + 16'd1;
        default: ;
      endcase
    end
  end

  assign y      = y_r;
  assign op_cnt = op_cnt_r;

endmodule
